// File: rtl/uart_pkg.sv
// Shared UART definitions, used by both the receiver and the transmitter.
// Holds the default frame geometry and the receiver state encoding.
// There are no ports, because this file is a package.
package uart_pkg;

  // Default data bits per frame and default sample ticks per bit period.
  localparam int DATA_BITS_DEF = 8;
  localparam int OSR_DEF       = 16;

  // Receiver state encoding. It is kept as plain constants so that older
  // tools and the transmitter can share the same values.
  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE      = 3'd0;
  localparam uart_state_t ST_START     = 3'd1;
  localparam uart_state_t ST_DATA      = 3'd2;
  localparam uart_state_t ST_STOP      = 3'd3;
  localparam uart_state_t ST_WAIT_HIGH = 3'd4;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Ports:
//   clk - destination clock
//   rst - asynchronous reset, active low; both flops load RESET_VAL
//   d   - asynchronous input
//   q   - synchronized output
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // The first flop may go metastable. The second flop gives it a full
  // cycle to settle before anything downstream uses the value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver (8N1 style, DATA_BITS data bits, one stop bit).
// The line is sampled on an external tick (bclk_en) that runs at OSR x baud.
// Ports:
//   clk          - system clock
//   rst          - asynchronous reset, active low
//   bclk_en      - one-clk sample tick at OSR x baud
//   rxd          - asynchronous serial line, idle high
//   rx_data      - last correctly framed word
//   rx_valid     - one-clk pulse when rx_data updates
//   rx_frame_err - one-clk pulse when the stop bit is sampled low
//   rx_busy      - high whenever the receiver is not idle
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int OSR       = OSR_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bclk_en,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int TW = $clog2(OSR);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_MID  = TW'(OSR / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OSR - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  uart_state_t          state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 rxd_s;

  // The line idles high, so the synchronizer resets to 1. This prevents a
  // false start bit from being seen right after reset.
  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  // The FSM and its counters advance only on sample ticks. The output
  // pulses default low every clk, so each pulse is exactly one cycle wide.
  // The start bit is checked half a bit after the falling edge. Every later
  // bit is then sampled one full bit period after the previous one, which
  // places each sample near the middle of its bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      if (bclk_en) begin
        case (state)
          ST_IDLE: begin
            if (!rxd_s) begin
              state    <= ST_START;
              tick_cnt <= '0;
            end
          end
          ST_START: begin
            if (tick_cnt == TICK_MID) begin
              tick_cnt <= '0;
              if (rxd_s) begin
                state <= ST_IDLE;
              end else begin
                state   <= ST_DATA;
                bit_cnt <= '0;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          ST_DATA: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt  <= '0;
              shift_reg <= {rxd_s, shift_reg[DATA_BITS-1:1]};
              bit_cnt   <= bit_cnt + BW'(1);
              if (bit_cnt == BIT_LAST) begin
                state <= ST_STOP;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          ST_STOP: begin
            // A start edge that lands on this tick is left for IDLE,
            // which checks the line again on the next tick.
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              if (rxd_s) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
                state    <= ST_IDLE;
              end else begin
                rx_frame_err <= 1'b1;
                state        <= ST_WAIT_HIGH;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          ST_WAIT_HIGH: begin
            // A line held low (a break) must release before the receiver
            // re-arms, so the break reports only one framing error.
            if (rxd_s) begin
              state <= ST_IDLE;
            end
          end
          default: begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Self-checking bench for uart_rx_oversample.
// The first frame uses the nominal 326-clk tick spacing. The remaining frames
// use a 10-clk tick so the run stays short.
module tb_uart_rx_oversample;

  localparam int DATA_BITS = 8;
  localparam int OSR       = 16;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         tick_div;
    int         bit_clks;
    int         gap_clks;
    bit         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 bclk_en;
  logic                 rxd;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_frame_err;
  logic                 rx_busy;

  int         checks = 0;
  int         errors = 0;
  exp_t       exp_q[$];
  logic [7:0] last_good;
  int         tick_div   = 326;
  bit         tick_on    = 1'b0;
  int         tick_phase = 0;
  logic       prev_valid = 1'b0;
  logic       prev_err   = 1'b0;
  vec_t       vecs[5];

  uart_rx_oversample #(.DATA_BITS(DATA_BITS), .OSR(OSR)) dut (
    .clk          (clk),
    .rst          (rst),
    .bclk_en      (bclk_en),
    .rxd          (rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  // Sample-tick source: one clk wide, every tick_div clocks, while tick_on is set.
  initial begin
    bclk_en = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_on && tick_phase >= tick_div - 1) begin
        bclk_en    = 1'b1;
        tick_phase = 0;
      end else begin
        bclk_en    = 1'b0;
        tick_phase = tick_phase + 1;
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives the first nbits of the frame {stop, data, start}, LSB first.
  task automatic apply_stimulus(input logic [7:0] data, input bit stop, input int bit_clks, input int nbits);
    logic [9:0] frame;
    frame = {stop, data, 1'b0};
    for (int b = 0; b < nbits; b++) begin
      rxd = frame[b];
      repeat (bit_clks) @(negedge clk);
    end
  endtask

  task automatic check_drained(input string name);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
    check_output(name, exp_q.size(), 0);
  endtask

  // Scoreboard side: each output pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rx_valid || rx_frame_err) begin
      check_output("both_pulses", {31'd0, rx_valid & rx_frame_err}, 0);
      if (rx_valid) check_output("valid_width", {31'd0, prev_valid}, 0);
      if (rx_frame_err) check_output("err_width", {31'd0, prev_err}, 0);
      if (exp_q.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("[TB] FAIL unexpected_pulse: got valid=%0b err=%0b data=%0h, expected no pulse at %0t", rx_valid, rx_frame_err, rx_data, $time);
      end else begin
        e = exp_q.pop_front();
        check_output("pulse_kind_is_err", {31'd0, rx_frame_err}, {31'd0, e.is_err});
        check_output("rx_data_at_pulse", {24'd0, rx_data}, {24'd0, e.data});
      end
    end
    prev_valid = rx_valid;
    prev_err   = rx_frame_err;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected completion at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Table of full frames: the data, stop bit, tick spacing, bit length in clocks, idle gap after the frame, and expected result.
    vecs[0] = '{8'hA5, 1'b1, 326, 16 * 326, 20, 1'b0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 10,  160,      0,  1'b0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 10,  160,      40, 1'b0, 8'hFF};
    vecs[3] = '{8'hC3, 1'b1, 10,  163,      40, 1'b0, 8'hC3};
    vecs[4] = '{8'hC3, 1'b1, 10,  157,      40, 1'b0, 8'hC3};

    rst       = 1'b0;
    rxd       = 1'b1;
    last_good = 8'h00;
    repeat (5) @(negedge clk);
    check_output("reset_rx_data", {24'd0, rx_data}, 0);
    check_output("reset_rx_valid", {31'd0, rx_valid}, 0);
    check_output("reset_rx_frame_err", {31'd0, rx_frame_err}, 0);
    check_output("reset_rx_busy", {31'd0, rx_busy}, 0);
    rst     = 1'b1;
    tick_on = 1'b1;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      tick_div = vecs[i].tick_div;
      exp_q.push_back('{vecs[i].exp_err, vecs[i].exp_data});
      if (!vecs[i].exp_err) last_good = vecs[i].exp_data;
      apply_stimulus(vecs[i].data, vecs[i].stop, vecs[i].bit_clks, 10);
      rxd = 1'b1;
      if (vecs[i].gap_clks > 0) begin
        repeat (vecs[i].gap_clks) @(negedge clk);
        check_drained($sformatf("frame_pending[%0d]", i));
        check_output($sformatf("busy_after_stop[%0d]", i), {31'd0, rx_busy}, 0);
        check_output($sformatf("rx_data_held[%0d]", i), {24'd0, rx_data}, {24'd0, last_good});
      end
    end

    // False start: the line is low for 4 ticks, then returns high.
    rxd = 1'b0;
    repeat (4 * 10) @(negedge clk);
    check_output("false_start_busy", {31'd0, rx_busy}, 1);
    rxd = 1'b1;
    for (int i = 0; i < 8 * 10 && rx_busy; i++) @(negedge clk);
    check_output("false_start_idle", {31'd0, rx_busy}, 0);
    repeat (40) @(negedge clk);
    check_output("false_start_no_pulse", exp_q.size(), 0);

    // With the tick stopped, a low line must not move the FSM.
    tick_on = 1'b0;
    rxd     = 1'b0;
    repeat (50) @(negedge clk);
    check_output("no_tick_busy", {31'd0, rx_busy}, 0);
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    tick_on = 1'b1;
    repeat (20) @(negedge clk);

    // Break: 0x3C with a low stop bit, then the line is held low 3 bit times in total.
    exp_q.push_back('{1'b1, last_good});
    apply_stimulus(8'h3C, 1'b0, 160, 10);
    repeat (2 * 160) @(negedge clk);
    check_drained("break_err_pending");
    check_output("break_wait_high_busy", {31'd0, rx_busy}, 1);
    check_output("break_rx_data_kept", {24'd0, rx_data}, {24'd0, last_good});
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check_output("break_release_idle", {31'd0, rx_busy}, 0);

    // Reset in the middle of data bit 4 of 0x96, then a clean 0x5A.
    apply_stimulus(8'h96, 1'b1, 160, 5);
    rxd = 1'b1;
    repeat (80) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_output("midreset_rx_data", {24'd0, rx_data}, 0);
    check_output("midreset_rx_busy", {31'd0, rx_busy}, 0);
    check_output("midreset_rx_valid", {31'd0, rx_valid | rx_frame_err}, 0);
    rst       = 1'b1;
    last_good = 8'h00;
    repeat (20) @(negedge clk);
    exp_q.push_back('{1'b0, 8'h5A});
    last_good = 8'h5A;
    apply_stimulus(8'h5A, 1'b1, 160, 10);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check_drained("after_reset_pending");
    check_output("after_reset_rx_data", {24'd0, rx_data}, 32'h5A);
    check_output("after_reset_busy", {31'd0, rx_busy}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
